wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback stage directly downstream of the load/store pipeline's result port (lsp_ix_*). It also receives results from the integer ALU pipe.
- Each cycle it arbitrates between the two sources, accepts at most one result, and drives the single register-file write port through a registered stage.
- It also provides forwarding/hazard information and the retire PC, and keeps a retired-instruction counter.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles a valid ALU result may lose arbitration before it is forcibly granted (range 1..15).
- XLEN, 64: datapath width.

Ports:
- clk  in  1  clock (single clock domain)
- rst  in  1  synchronous reset, active-high
- ip_wb_dst  in  5  ALU destination register
- ip_wb_result  in  XLEN  ALU result
- ip_wb_pc  in  XLEN  ALU instruction PC
- ip_wb_wb_en  in  1  ALU result writes the register file
- ip_wb_valid  in  1  ALU result valid
- ip_wb_ready  out  1  ALU result accepted this cycle
- lsp_ix_dst  in  5  LSP destination register
- lsp_ix_result  in  XLEN  LSP load data, already extended
- lsp_ix_pc  in  XLEN  LSP instruction PC
- lsp_ix_wb_en  in  1  LSP result writes the register file
- lsp_ix_valid  in  1  LSP result valid
- lsp_ix_ready  out  1  LSP result accepted this cycle
- rf_wr_en  out  1  register-file write enable
- rf_wr_addr  out  5  register-file write address
- rf_wr_data  out  XLEN  register-file write data
- wb_fwd_valid  out  1  forwarding entry valid (equals rf_wr_en)
- wb_fwd_dst  out  5  forwarding destination (equals rf_wr_addr)
- wb_fwd_data  out  XLEN  forwarding data (equals rf_wr_data)
- wb_retire_valid  out  1  one instruction retired this cycle
- wb_retire_pc  out  XLEN  PC of the retired instruction
- wb_instret  out  64  retired-instruction count

Behaviour:
- Handshake: a source transfers when valid && ready in the same cycle. Sources hold their data stable while valid && !ready.
- ready is combinational from the grant: ip_wb_ready = grant_alu, lsp_ix_ready = grant_lsp. At most one grant per cycle. No grant is given to a source whose valid is low.
- Arbitration:
  - LSP wins by default, because its result buffer is only 1 deep.
  - Starvation counter starve_cnt (4 bit):
    - increments when ip_wb_valid && !grant_alu;
    - clears on grant_alu, or when ip_wb_valid is low;
    - saturates at STARVE_LIMIT.
  - When starve_cnt == STARVE_LIMIT and ip_wb_valid, the ALU is granted even if LSP is valid.
- Output stage, registered, latency 1 cycle from handshake:
  - rf_wr_en <= granted wb_en && dst != 0; x0 writes are suppressed but still retire.
  - rf_wr_addr and rf_wr_data <= winner's dst and result. They update on every grant and hold otherwise.
  - wb_retire_valid <= any grant; wb_retire_pc <= winner's pc.
  - A store (wb_en=0) retires without a register-file write.
- wb_instret increments by 1 in the cycle after each grant, i.e. the cycle in which wb_retire_valid is high. Wrap-around from 2^64-1 to 0 is silent.
- Reset (sync, rst high), regardless of in-flight handshakes:
  - rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0;
  - wb_retire_valid=0, wb_retire_pc=0, wb_instret=0, starve_cnt=0;
  - ready outputs are forced 0 while rst is high.
  - A transfer attempted during a reset cycle is not accepted and does not retire.
- Simultaneous valid on both sources, with starve_cnt < STARVE_LIMIT: LSP is granted, ALU stalls, starve_cnt increments.
- No internal buffering. Back-pressure reaches a source only through lost arbitration.

Decomposition:
- Shared package/defines: XLEN, register index width (5), and the x0 register constant. These go in defines.vh next to the MW_* memory-width codes.
- One natural sub-module: wb_starve_arb. It holds the 2-input fixed-priority arbiter with the saturating starvation counter and outputs the grant vector.
- Output registers and the instret counter stay in wb_arbiter.

Test Plan:
- Reset, then LSP-only traffic: LSP presents dst=5, result=0xDEAD_BEEF, pc=0x8000_0010, wb_en=1, valid=1. Required: lsp_ix_ready=1 the same cycle; next cycle rf_wr_en=1, addr=5, data=0xDEAD_BEEF, retire_pc=0x8000_0010, instret=1.
- x0 and store: ALU presents dst=0, wb_en=1; then LSP presents wb_en=0. Required: both retire (instret +2) and rf_wr_en stays 0 in both output cycles.
- Contention with STARVE_LIMIT=4: both sources valid for 6 cycles. Required grants are LSP, LSP, LSP, LSP, ALU, then LSP. starve_cnt returns to 0 after the ALU grant.
- Back-pressure hold: ALU valid and stalled for 3 cycles with result=0x1234. Required: ip_wb_ready=0 during the stall; the value written is exactly 0x1234 once granted.
- Reset mid-operation: assert rst in the cycle LSP is valid. Required: lsp_ix_ready=0, and next cycle all outputs are 0 with wb_instret=0. After rst deasserts, the still-valid LSP result is accepted.
- Counter wrap: force wb_instret to 0xFFFF_FFFF_FFFF_FFFF, then one grant. Required: wb_instret=0 in the next cycle.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared writeback types: register index width, x0 constant, memory-width codes
// and the two-source grant vector used between the arbiter and the output stage.
package wb_arbiter_pkg;

    localparam int REG_W = 5;
    localparam int STARVE_W = 4;
    localparam logic [REG_W-1:0] REG_X0 = '0;

    typedef enum logic [2:0] {
        MW_B  = 3'd0,
        MW_H  = 3'd1,
        MW_W  = 3'd2,
        MW_D  = 3'd3,
        MW_BU = 3'd4,
        MW_HU = 3'd5,
        MW_WU = 3'd6
    } mw_e;

    typedef struct packed {
        logic lsp;
        logic alu;
    } grant_t;

    // Architectural x0 is hardwired zero, so writes to it are dropped.
    function automatic logic rf_we(input logic wb_en, input logic [REG_W-1:0] dst);
        return wb_en && (dst != REG_X0);
    endfunction

endpackage

// File: rtl/wb_starve_arb.sv
// Two-input fixed-priority arbiter (LSP over ALU), combinational grant, no buffering.
// A valid ALU result that loses STARVE_LIMIT consecutive times is granted next.
module wb_starve_arb
    import wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   alu_vld_i,
    input  logic   lsp_vld_i,
    output grant_t grant_o
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;
    logic                force_alu;

    assign force_alu = alu_vld_i && (starve_q == LIMIT);

    // Grants are masked during reset so no transfer completes in that cycle.
    always_comb begin
        grant_o = '0;
        if (!rst) begin
            grant_o.alu = alu_vld_i && (force_alu || !lsp_vld_i);
            grant_o.lsp = lsp_vld_i && !force_alu;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!alu_vld_i || grant_o.alu) begin
            starve_d = '0;
        end else if (starve_q < LIMIT) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one of ALU/LSP per cycle, registers the RF write, retire PC
// and instret one cycle after the handshake; losers see ready low and must hold.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN = 64
) (
    input  logic             clk,
    input  logic             rst,

    input  logic [REG_W-1:0] ip_wb_dst,
    input  logic [XLEN-1:0]  ip_wb_result,
    input  logic [XLEN-1:0]  ip_wb_pc,
    input  logic             ip_wb_wb_en,
    input  logic             ip_wb_valid,
    output logic             ip_wb_ready,

    input  logic [REG_W-1:0] lsp_ix_dst,
    input  logic [XLEN-1:0]  lsp_ix_result,
    input  logic [XLEN-1:0]  lsp_ix_pc,
    input  logic             lsp_ix_wb_en,
    input  logic             lsp_ix_valid,
    output logic             lsp_ix_ready,

    output logic             rf_wr_en,
    output logic [REG_W-1:0] rf_wr_addr,
    output logic [XLEN-1:0]  rf_wr_data,

    output logic             wb_fwd_valid,
    output logic [REG_W-1:0] wb_fwd_dst,
    output logic [XLEN-1:0]  wb_fwd_data,

    output logic             wb_retire_valid,
    output logic [XLEN-1:0]  wb_retire_pc,
    output logic [63:0]      wb_instret
);

    grant_t grant;

    wb_starve_arb #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .alu_vld_i (ip_wb_valid),
        .lsp_vld_i (lsp_ix_valid),
        .grant_o   (grant)
    );

    assign ip_wb_ready  = grant.alu;
    assign lsp_ix_ready = grant.lsp;

    logic             any_grant;
    logic [REG_W-1:0] win_dst;
    logic [XLEN-1:0]  win_result;
    logic [XLEN-1:0]  win_pc;
    logic             win_wb_en;

    assign any_grant = grant.alu || grant.lsp;

    always_comb begin
        win_dst    = lsp_ix_dst;
        win_result = lsp_ix_result;
        win_pc     = lsp_ix_pc;
        win_wb_en  = lsp_ix_wb_en;
        if (grant.alu) begin
            win_dst    = ip_wb_dst;
            win_result = ip_wb_result;
            win_pc     = ip_wb_pc;
            win_wb_en  = ip_wb_wb_en;
        end
    end

    logic             rf_en_q,   rf_en_d;
    logic [REG_W-1:0] rf_addr_q, rf_addr_d;
    logic [XLEN-1:0]  rf_data_q, rf_data_d;
    logic             ret_vld_q, ret_vld_d;
    logic [XLEN-1:0]  ret_pc_q,  ret_pc_d;
    logic [63:0]      instret_q, instret_d;

    // Address/data hold between grants; only the enable and retire strobe drop.
    always_comb begin
        rf_en_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        ret_vld_d = any_grant;
        ret_pc_d  = ret_pc_q;
        instret_d = instret_q;
        if (any_grant) begin
            rf_en_d   = rf_we(win_wb_en, win_dst);
            rf_addr_d = win_dst;
            rf_data_d = win_result;
            ret_pc_d  = win_pc;
            instret_d = instret_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_en_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            ret_vld_q <= 1'b0;
            ret_pc_q  <= '0;
            instret_q <= '0;
        end else begin
            rf_en_q   <= rf_en_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            ret_vld_q <= ret_vld_d;
            ret_pc_q  <= ret_pc_d;
            instret_q <= instret_d;
        end
    end

    assign rf_wr_en        = rf_en_q;
    assign rf_wr_addr      = rf_addr_q;
    assign rf_wr_data      = rf_data_q;
    assign wb_fwd_valid    = rf_en_q;
    assign wb_fwd_dst      = rf_addr_q;
    assign wb_fwd_data     = rf_data_q;
    assign wb_retire_valid = ret_vld_q;
    assign wb_retire_pc    = ret_pc_q;
    assign wb_instret      = instret_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, every cycle compared
// against a behavioural writeback model kept in this file.
module tb_wb_arbiter;

    localparam int LIMIT = 4;
    localparam int XLEN  = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      ip_wb_dst;
    logic [XLEN-1:0] ip_wb_result, ip_wb_pc;
    logic            ip_wb_wb_en, ip_wb_valid, ip_wb_ready;
    logic [4:0]      lsp_ix_dst;
    logic [XLEN-1:0] lsp_ix_result, lsp_ix_pc;
    logic            lsp_ix_wb_en, lsp_ix_valid, lsp_ix_ready;
    logic            rf_wr_en;
    logic [4:0]      rf_wr_addr;
    logic [XLEN-1:0] rf_wr_data;
    logic            wb_fwd_valid;
    logic [4:0]      wb_fwd_dst;
    logic [XLEN-1:0] wb_fwd_data;
    logic            wb_retire_valid;
    logic [XLEN-1:0] wb_retire_pc;
    logic [63:0]     wb_instret;

    always #5 clk = ~clk;

    wb_arbiter #(.STARVE_LIMIT(LIMIT), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .ip_wb_dst(ip_wb_dst), .ip_wb_result(ip_wb_result), .ip_wb_pc(ip_wb_pc),
        .ip_wb_wb_en(ip_wb_wb_en), .ip_wb_valid(ip_wb_valid), .ip_wb_ready(ip_wb_ready),
        .lsp_ix_dst(lsp_ix_dst), .lsp_ix_result(lsp_ix_result), .lsp_ix_pc(lsp_ix_pc),
        .lsp_ix_wb_en(lsp_ix_wb_en), .lsp_ix_valid(lsp_ix_valid), .lsp_ix_ready(lsp_ix_ready),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_dst(wb_fwd_dst), .wb_fwd_data(wb_fwd_data),
        .wb_retire_valid(wb_retire_valid), .wb_retire_pc(wb_retire_pc), .wb_instret(wb_instret)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: expected registered outputs and consecutive-loss count of the ALU.
    int              m_losses;
    logic            m_rf_en, m_rv, m_g_alu, m_g_lsp;
    logic [4:0]      m_addr;
    logic [XLEN-1:0] m_data, m_rpc;
    longint unsigned m_instret;
    logic            s_alu_rdy, s_lsp_rdy;

    task automatic model_reset();
        m_losses = 0; m_rf_en = 0; m_rv = 0; m_addr = 0; m_data = 0; m_rpc = 0; m_instret = 0;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cyc();
        logic force_alu;
        @(negedge clk);
        force_alu = ip_wb_valid && (m_losses >= LIMIT);
        m_g_alu = !rst && ip_wb_valid && (force_alu || !lsp_ix_valid);
        m_g_lsp = !rst && lsp_ix_valid && !force_alu;
        s_alu_rdy = ip_wb_ready;
        s_lsp_rdy = lsp_ix_ready;
        chk("ip_wb_ready", ip_wb_ready, m_g_alu);
        chk("lsp_ix_ready", lsp_ix_ready, m_g_lsp);
        chk("rf_wr_en", rf_wr_en, m_rf_en);
        chk("rf_wr_addr", rf_wr_addr, m_addr);
        chk("rf_wr_data", rf_wr_data, m_data);
        chk("wb_fwd_valid", wb_fwd_valid, m_rf_en);
        chk("wb_fwd_dst", wb_fwd_dst, m_addr);
        chk("wb_fwd_data", wb_fwd_data, m_data);
        chk("wb_retire_valid", wb_retire_valid, m_rv);
        chk("wb_retire_pc", wb_retire_pc, m_rpc);
        chk("wb_instret", wb_instret, m_instret);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_rv = m_g_alu || m_g_lsp;
            m_rf_en = 0;
            if (m_g_alu) begin
                m_rf_en = ip_wb_wb_en && (ip_wb_dst != 0);
                m_addr = ip_wb_dst; m_data = ip_wb_result; m_rpc = ip_wb_pc;
            end else if (m_g_lsp) begin
                m_rf_en = lsp_ix_wb_en && (lsp_ix_dst != 0);
                m_addr = lsp_ix_dst; m_data = lsp_ix_result; m_rpc = lsp_ix_pc;
            end
            if (m_rv) m_instret = m_instret + 1;
            if (!ip_wb_valid || m_g_alu) m_losses = 0;
            else if (m_losses < LIMIT) m_losses++;
        end
        #1;
    endtask

    task automatic set_alu(input logic v, input logic [4:0] d, input logic [63:0] r,
                           input logic [63:0] pc, input logic we);
        ip_wb_valid = v; ip_wb_dst = d; ip_wb_result = r; ip_wb_pc = pc; ip_wb_wb_en = we;
    endtask

    task automatic set_lsp(input logic v, input logic [4:0] d, input logic [63:0] r,
                           input logic [63:0] pc, input logic we);
        lsp_ix_valid = v; lsp_ix_dst = d; lsp_ix_result = r; lsp_ix_pc = pc; lsp_ix_wb_en = we;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        string grant_seq;
        string exp_seq;
        model_reset();
        m_g_alu = 0; m_g_lsp = 0;
        rst = 1;
        set_alu(0, 0, 0, 0, 0);
        set_lsp(0, 0, 0, 0, 0);
        #1;
        cyc(); cyc();
        chk("reset_instret", wb_instret, 0);
        chk("reset_rf_en", rf_wr_en, 0);
        rst = 0;
        cyc();

        // LSP-only single transfer
        set_lsp(1, 5, 64'hDEAD_BEEF, 64'h8000_0010, 1);
        cyc();
        chk("lsp_only_ready", s_lsp_rdy, 1);
        set_lsp(0, 0, 0, 0, 0);
        chk("lsp_only_rf_en", rf_wr_en, 1);
        chk("lsp_only_addr", rf_wr_addr, 5);
        chk("lsp_only_data", rf_wr_data, 64'hDEAD_BEEF);
        chk("lsp_only_pc", wb_retire_pc, 64'h8000_0010);
        chk("lsp_only_instret", wb_instret, 1);
        cyc();

        // x0 write then a store: both retire, neither writes
        set_alu(1, 0, 64'h55, 64'h8000_0020, 1);
        cyc();
        set_alu(0, 0, 0, 0, 0);
        chk("x0_rf_en", rf_wr_en, 0);
        chk("x0_retire", wb_retire_valid, 1);
        set_lsp(1, 9, 64'h66, 64'h8000_0024, 0);
        cyc();
        set_lsp(0, 0, 0, 0, 0);
        chk("store_rf_en", rf_wr_en, 0);
        chk("store_retire", wb_retire_valid, 1);
        chk("x0_store_instret", wb_instret, 3);
        cyc();

        // Contention: ALU forced through after LIMIT losses, then counter restarts
        set_alu(1, 3, 64'hA0, 64'h100, 1);
        set_lsp(1, 4, 64'hB0, 64'h200, 1);
        grant_seq = "";
        exp_seq = "LLLLALLLLAL";
        for (int i = 0; i < 11; i++) begin
            cyc();
            grant_seq = {grant_seq, s_alu_rdy ? "A" : (s_lsp_rdy ? "L" : "-")};
            if (m_g_alu) set_alu(1, 5'(i + 1), rnd64(), rnd64(), 1);
            if (m_g_lsp) set_lsp(1, 5'(i + 10), rnd64(), rnd64(), 1);
        end
        chk("contention_seq", 64'(grant_seq == exp_seq), 1);
        set_alu(0, 0, 0, 0, 0);
        set_lsp(0, 0, 0, 0, 0);
        cyc();

        // Back-pressure: ALU holds 0x1234 while LSP wins three times
        set_alu(1, 7, 64'h1234, 64'h300, 1);
        for (int i = 0; i < 3; i++) begin
            set_lsp(1, 5'(20 + i), rnd64(), rnd64(), 1);
            cyc();
            chk("bp_alu_stalled", s_alu_rdy, 0);
        end
        set_lsp(0, 0, 0, 0, 0);
        cyc();
        chk("bp_alu_granted", s_alu_rdy, 1);
        set_alu(0, 0, 0, 0, 0);
        chk("bp_data", rf_wr_data, 64'h1234);
        chk("bp_addr", rf_wr_addr, 7);
        cyc();

        // Reset while LSP is valid: not accepted, then accepted after reset
        set_lsp(1, 11, 64'hCAFE, 64'h400, 1);
        rst = 1;
        cyc();
        chk("rst_lsp_ready", s_lsp_rdy, 0);
        chk("rst_instret", wb_instret, 0);
        chk("rst_rf_data", rf_wr_data, 0);
        chk("rst_retire_pc", wb_retire_pc, 0);
        rst = 0;
        cyc();
        chk("post_rst_ready", s_lsp_rdy, 1);
        set_lsp(0, 0, 0, 0, 0);
        chk("post_rst_instret", wb_instret, 1);
        chk("post_rst_data", rf_wr_data, 64'hCAFE);

        // Random traffic with occasional resets; sources hold while stalled
        for (int i = 0; i < 400; i++) begin
            if (!(ip_wb_valid && !m_g_alu))
                set_alu($urandom_range(0, 2) != 0, 5'($urandom), rnd64(), rnd64(), 1'($urandom));
            if (!(lsp_ix_valid && !m_g_lsp))
                set_lsp($urandom_range(0, 2) != 0, 5'($urandom), rnd64(), rnd64(), 1'($urandom));
            rst = ($urandom_range(0, 59) == 0);
            cyc();
        end
        rst = 0;
        set_alu(0, 0, 0, 0, 0);
        set_lsp(0, 0, 0, 0, 0);
        cyc();

        // instret wrap-around
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        set_alu(1, 2, 64'h77, 64'h500, 1);
        cyc();
        set_alu(0, 0, 0, 0, 0);
        chk("instret_wrap", wb_instret, 0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
